alu_issue_ctrl: RTL
===================

Name: alu_issue_ctrl

Overview:
Sequential front-end that feeds the 4-bit combinational ALU and registers its outputs. Commands (op, A, B) are accepted over a valid/ready handshake and buffered in a small FIFO. Each command is driven onto the ALU through registered operands and held for a fixed settle window. The ALU result, overflow and zero are then captured into a one-entry output register with its own valid/ready handshake.

Parameters:
DEPTH, 4, command FIFO entries (power of two, >=2)
SETTLE_CYCLES, 3, extra clock edges ALU operands are held stable before capture (>=1)

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  command present
in_ready  out  1  FIFO can accept
in_op  in  2  ALU op code
in_a  in  4  operand A
in_b  in  4  operand B
alu_a  out  4  registered operand A to ALU
alu_b  out  4  registered operand B to ALU
alu_op  out  2  registered op to ALU
alu_result  in  4  ALU result
alu_overflow  in  1  ALU overflow
alu_zero  in  1  ALU zero
out_valid  out  1  captured result available
out_ready  in  1  consumer takes result
out_result  out  4  captured result
out_overflow  out  1  captured overflow
out_zero  out  1  captured zero
out_op  out  2  op that produced the captured result
busy  out  1  FSM not IDLE or FIFO non-empty

Behaviour:
- Reset: all state clears asynchronously while rst_n=0.
  - FIFO empties; FSM goes to IDLE; counter=0.
  - alu_a, alu_b, alu_op, out_result, out_op = 0; out_overflow, out_zero, out_valid, busy = 0.
  - in_ready=0 while rst_n=0.
  - Reset mid-operation discards all buffered commands and any uncaptured result.
- ALU op meaning (checked by the bench):
  - 00 = A+B
  - 01 = |A-B|, computed as the two's-complement magnitude of the difference
  - 10 = A-B
  - 11 = A+B
  - overflow = carry(3) XOR carry-out of the add/sub.
  - zero reflects the raw sum/difference, not the magnitude.
- FIFO:
  - in_ready = (count < DEPTH).
  - Push on in_valid && in_ready. No push when full, even if a pop occurs in the same cycle.
  - Simultaneous push and pop: count unchanged. Pointers wrap modulo DEPTH.
- FSM states: IDLE, SETTLE.
  - IDLE: if FIFO non-empty, pop the head on the edge, load alu_a/alu_b/alu_op, load counter=SETTLE_CYCLES, go to SETTLE. Otherwise stay.
  - SETTLE, counter>0: decrement counter.
  - SETTLE, counter==0 and (!out_valid || out_ready): capture alu_result/overflow/zero plus alu_op into the output register, set out_valid, go to IDLE.
  - SETTLE, counter==0 and output slot occupied with no out_ready: stall in SETTLE. Operands are held unchanged.
- Output register:
  - out_valid clears on out_ready unless a capture occurs on the same edge (capture wins).
  - Outputs are stable while out_valid && !out_ready.
- Latency and throughput:
  - Command accepted at edge 0 into an empty FIFO with the FSM idle: popped at edge 1, captured at edge 2+SETTLE_CYCLES. out_valid is visible after edge 5 for the default.
  - Throughput is one command per SETTLE_CYCLES+2 cycles.
- Ordering: results emerge in strict command order. No command is dropped or duplicated.
- alu_* hold their last value in IDLE.

Decomposition:
- Shared package alu_pkg holds:
  - ALU_W=4
  - op constants OP_ADD=2'b00, OP_ABSDIFF=2'b01, OP_SUB=2'b10, OP_ADD2=2'b11
  - the issue_state_t enum {IDLE, SETTLE}
  - the packed command struct {op, a, b}
- One natural sub-module: cmd_fifo.
  - Parameterised by DEPTH and struct width.
  - Ports: push/pop/full/empty/count, same clk/rst_n.

Test Plan:
1. Single op 00, A=3, B=4, out_ready=1 -> out_result=7, overflow=0, zero=0, out_op=00. out_valid rises after edge 5 from acceptance.
2. Op 01, A=2, B=5 -> out_result=3 (raw diff 1101 → magnitude 0011), zero=0. Op 10, A=5, B=5 -> out_result=0, zero=1, overflow=0.
3. Op 00, A=7, B=1 -> out_result=8 (1000), overflow=1. Op 10, A=8, B=1 -> out_result=7, overflow=1.
4. Push 5 commands back-to-back with out_ready=0 -> in_ready drops after 4 are buffered. First result is captured, then the FSM stalls in SETTLE with alu_* stable. Releasing out_ready drains all results in order with correct values.
5. Push and pop on the same edge with FIFO count=2 -> count stays 2. Pointer wrap after 6 sequential commands -> results still in order.
6. Assert rst_n=0 during SETTLE with 3 commands queued -> all outputs immediately 0, in_ready=0. After release: in_ready=1, busy=0, no stale out_valid.

Source files
------------

// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg : shared widths, op codes, issue FSM states and command record
// Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

package alu_pkg;

  localparam int ALU_W = 4;

  localparam logic [1:0] OP_ADD     = 2'b00;
  localparam logic [1:0] OP_ABSDIFF = 2'b01;
  localparam logic [1:0] OP_SUB     = 2'b10;
  localparam logic [1:0] OP_ADD2    = 2'b11;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    SETTLE = 1'b1
  } issue_state_t;

  typedef struct packed {
    logic [1:0]       op;
    logic [ALU_W-1:0] a;
    logic [ALU_W-1:0] b;
  } cmd_t;

  localparam int CMD_W = $bits(cmd_t);

endpackage

`default_nettype wire

// File: rtl/alu_issue_ctrl_cmd_fifo.sv
// -----------------------------------------------------------------------------
// cmd_fifo : power-of-two circular command buffer, async active-low reset
// Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 10
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             do_push;
  logic             do_pop;

  assign full    = (count_q == (PTR_W+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rdata   = mem_q[rd_ptr_q];
  // A full FIFO refuses the push even when a pop frees a slot on the same edge.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = wdata;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

`default_nettype wire

// File: rtl/alu_issue_ctrl.sv
// -----------------------------------------------------------------------------
// alu_issue_ctrl : buffers ALU commands, holds operands for a settle window,
//                  then captures the ALU outputs into a valid/ready slot. Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter int DEPTH         = 4,
  parameter int SETTLE_CYCLES = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic [ALU_W-1:0] in_a,
  input  logic [ALU_W-1:0] in_b,
  output logic [ALU_W-1:0] alu_a,
  output logic [ALU_W-1:0] alu_b,
  output logic [1:0]       alu_op,
  input  logic [ALU_W-1:0] alu_result,
  input  logic             alu_overflow,
  input  logic             alu_zero,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ALU_W-1:0] out_result,
  output logic             out_overflow,
  output logic             out_zero,
  output logic [1:0]       out_op,
  output logic             busy
);

  localparam int CNT_W  = $clog2(SETTLE_CYCLES + 1);
  localparam int FCNT_W = $clog2(DEPTH) + 1;

  cmd_t              push_cmd;
  cmd_t              head_cmd;
  logic              fifo_full;
  logic              fifo_empty;
  logic              fifo_pop;
  logic [FCNT_W-1:0] fifo_count;

  issue_state_t      state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ALU_W-1:0]  alu_a_q, alu_a_d;
  logic [ALU_W-1:0]  alu_b_q, alu_b_d;
  logic [1:0]        alu_op_q, alu_op_d;
  logic              out_valid_q, out_valid_d;
  logic [ALU_W-1:0]  out_result_q, out_result_d;
  logic              out_overflow_q, out_overflow_d;
  logic              out_zero_q, out_zero_d;
  logic [1:0]        out_op_q, out_op_d;

  assign push_cmd = '{op: in_op, a: in_a, b: in_b};
  // Held low during reset so nothing is accepted into a FIFO being cleared.
  assign in_ready = rst_n && !fifo_full;

  cmd_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (CMD_W)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (in_valid && in_ready),
    .wdata (push_cmd),
    .pop   (fifo_pop),
    .rdata (head_cmd),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    alu_a_d        = alu_a_q;
    alu_b_d        = alu_b_q;
    alu_op_d       = alu_op_q;
    out_valid_d    = out_valid_q;
    out_result_d   = out_result_q;
    out_overflow_d = out_overflow_q;
    out_zero_d     = out_zero_q;
    out_op_d       = out_op_q;
    fifo_pop       = 1'b0;

    if (out_ready) begin
      out_valid_d = 1'b0;
    end

    unique case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          alu_a_d  = head_cmd.a;
          alu_b_d  = head_cmd.b;
          alu_op_d = head_cmd.op;
          cnt_d    = CNT_W'(SETTLE_CYCLES);
          state_d  = SETTLE;
        end
      end
      SETTLE: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else if (!out_valid_q || out_ready) begin
          // A capture overrides the ready-driven clear of out_valid above.
          out_valid_d    = 1'b1;
          out_result_d   = alu_result;
          out_overflow_d = alu_overflow;
          out_zero_d     = alu_zero;
          out_op_d       = alu_op_q;
          state_d        = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      alu_a_q        <= '0;
      alu_b_q        <= '0;
      alu_op_q       <= '0;
      out_valid_q    <= 1'b0;
      out_result_q   <= '0;
      out_overflow_q <= 1'b0;
      out_zero_q     <= 1'b0;
      out_op_q       <= '0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      alu_a_q        <= alu_a_d;
      alu_b_q        <= alu_b_d;
      alu_op_q       <= alu_op_d;
      out_valid_q    <= out_valid_d;
      out_result_q   <= out_result_d;
      out_overflow_q <= out_overflow_d;
      out_zero_q     <= out_zero_d;
      out_op_q       <= out_op_d;
    end
  end

  assign alu_a        = alu_a_q;
  assign alu_b        = alu_b_q;
  assign alu_op       = alu_op_q;
  assign out_valid    = out_valid_q;
  assign out_result   = out_result_q;
  assign out_overflow = out_overflow_q;
  assign out_zero     = out_zero_q;
  assign out_op       = out_op_q;
  assign busy         = (state_q != IDLE) || (fifo_count != '0);

endmodule

`default_nettype wire
